iter_div: RTL and testbench

Multi-cycle 32-bit integer divider for the MIPS core's multiply/divide path. It sits directly upstream of the HI/LO register muxes. It takes Rs (dividend) and Rt (divisor) from the register file on a one-cycle start pulse from the instruction decoder, and returns quotient (to LO) and remainder (to HI) after a fixed latency. While the result is pending it asserts busy so the control path can stall the PC.

---
 rtl/mdu_pkg.sv | 45 ++++
 rtl/iter_div.sv | 141 ++++++++++++++
 tb/tb_iter_div.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types, constants and helpers for the multiply/divide unit
//
// Purpose: state encoding for the iterative divider, its fixed latency, and
// the magnitude/negate helpers shared by the divider and the planned
// multi-cycle multiplier.
// Ports: none (package).

package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  // Cycles from the accepting edge to the edge that raises done.
  localparam int DIV_LATENCY = MDU_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Two's-complement magnitude when signed_mode is set; raw value otherwise.
  // The most negative value maps onto itself, which is the correct unsigned
  // magnitude once the result is read as unsigned.
  function automatic logic [MDU_WIDTH-1:0] mdu_abs(
    input logic [MDU_WIDTH-1:0] value,
    input logic                 signed_mode
  );
    if (signed_mode && value[MDU_WIDTH-1]) begin
      return -value;
    end
    return value;
  endfunction

  // Conditional negate, modulo 2^MDU_WIDTH.
  function automatic logic [MDU_WIDTH-1:0] mdu_neg(
    input logic [MDU_WIDTH-1:0] value,
    input logic                 negate
  );
    if (negate) begin
      return -value;
    end
    return value;
  endfunction

endpackage

// File: rtl/iter_div.sv
// rtl/iter_div.sv - multi-cycle restoring divider for the MIPS DIV/DIVU path
//
// Purpose: divides dividend (Rs) by divisor (Rt), one quotient bit per cycle,
// MSB first, on operand magnitudes with a sign fix-up at the end. Quotient
// feeds LO, remainder feeds HI.
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   start        one-cycle request, honoured only while idle
//   is_signed    1 = DIV, 0 = DIVU (latched with start)
//   dividend     Rs value (latched with start)
//   divisor      Rt value (latched with start)
//   busy         high from the cycle after start through the done cycle
//   done         one-cycle result-valid pulse
//   quotient     LO result, held until the next result
//   remainder    HI result, held until the next result
//   div_by_zero  divisor was zero, held with the results

module iter_div
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       r_state;
  div_state_t       w_state_next;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dz;

  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic             w_accept;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // The done cycle is still IDLE in the state register, but busy is high
  // there, so a start in that cycle must also be refused.
  assign w_accept = (r_state == IDLE) && start && !r_done;

  // Partial remainder widened by one bit so the shifted-out MSB takes part in
  // the compare. When the compare passes the difference is below the divisor,
  // so the low WIDTH bits of the subtraction are exact.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
  assign w_diff   = w_rem_sh[WIDTH-1:0] - r_dvs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_next = RUN;
      RUN:  if (r_cnt == CW'(1)) w_state_next = DONE;
      DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem         <= '0;
      r_quo         <= '0;
      r_dvs         <= '0;
      r_cnt         <= '0;
      r_sign_q      <= 1'b0;
      r_sign_r      <= 1'b0;
      r_dz          <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_quo    <= mdu_abs(dividend, is_signed);
            r_dvs    <= mdu_abs(divisor, is_signed);
            r_rem    <= '0;
            r_cnt    <= CW'(WIDTH);
            r_sign_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_sign_r <= is_signed & dividend[WIDTH-1];
            r_dz     <= (divisor == '0);
          end
        end
        RUN: begin
          r_rem <= w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - CW'(1);
        end
        DONE: begin
          r_done        <= 1'b1;
          // With a zero divisor every step subtracts nothing, so the
          // remainder ends as |dividend|; undoing the dividend sign gives
          // back the raw dividend. Only the quotient needs overriding.
          r_quotient    <= r_dz ? '1 : mdu_neg(r_quo, r_sign_q);
          r_remainder   <= mdu_neg(r_rem, r_sign_r);
          r_div_by_zero <= r_dz;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != IDLE) || r_done;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_iter_div.sv
// tb/tb_iter_div.sv - scoreboard bench for iter_div against an arithmetic reference

module tb_iter_div;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  iter_div #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           issue_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain integer division with MIPS conventions layered on top.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb_;
    sa  = a;
    sb_ = b;
    e.issue_cyc = 0;
    e.dz = 1'b0;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else if (!s) begin
      e.q = a / b; e.r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = '0;
    end else begin
      e.q = sa / sb_; e.r = sa % sb_;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request,
  // arrive exactly DIV_LATENCY edges after the accepting edge, and keep busy high.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
        chk("latency", cyc - e.issue_cyc, DIV_LATENCY + 1);
        chk("busy_in_done", {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit push);
    exp_t e;
    wait_idle();
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    if (push) begin
      e = model(a, b, s);
      e.issue_cyc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_dz", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    issue(32'd100, 32'd7, 1'b0, 1'b1);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    issue(32'd5, 32'd0, 1'b1, 1'b1);
    issue(32'd5, 32'd0, 1'b0, 1'b1);
    issue(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1);
    issue(32'h8000_0000, 32'd0, 1'b1, 1'b1);

    // Start while running and during the done cycle must be ignored
    issue(32'd100, 32'd7, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    start = 1'b1; dividend = 32'd9; divisor = 32'd3; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    start = 1'b1; dividend = 32'd77; divisor = 32'd5;
    @(negedge clk);
    start = 1'b0;
    chk("done_cycle_start_ignored", {31'd0, busy}, 32'd0);
    issue(32'd9, 32'd3, 1'b0, 1'b1);
    wait_idle();

    // Reset mid-run aborts with no done pulse afterwards
    issue(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (13) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_dz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_stays_idle", {31'd0, busy}, 32'd0);
    issue(32'd100, 32'd7, 1'b0, 1'b1);

    // Randomised operands, biased toward interesting divisors
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 15);
        3: b = -($urandom_range(1, 15));
        4: b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      issue(a, b, 1'($urandom), 1'b1);
    end

    begin
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
